// File: rtl/squash_arbiter_pkg.sv
// squash_arbiter_pkg
// Shared types for the squash arbiter and the ROB/LSQ age logic. It holds the
// ROB index, the writeback and squash payloads, the pending-cause record and
// the ROB age comparison.
package squash_arbiter_pkg;

  localparam int XLEN                = 32;
  localparam int ROB_IDX_WIDTH       = 5;
  localparam int MEMDEP_FOLDPC_WIDTH = 10;

  typedef logic [XLEN-1:0]                xlen_t;
  typedef logic [MEMDEP_FOLDPC_WIDTH-1:0] foldpc_t;

  // ROB slot index plus a wrap flag that toggles every time idx wraps around
  typedef struct packed {
    logic                     flag;
    logic [ROB_IDX_WIDTH-1:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t rob_idx;
    logic    has_mispred;
    logic    branch_taken;
    xlen_t   target_pc;
    xlen_t   branch_npc;
  } branchwbInfo_t;

  typedef struct packed {
    logic    dueToBranch;
    logic    dueToViolation;
    logic    branch_taken;
    xlen_t   arch_pc;
    foldpc_t store_foldpc;
    foldpc_t load_foldpc;
  } squashInfo_t;

  typedef enum logic {
    srcBranch,
    srcViolation
  } squashSrc_t;

  typedef struct packed {
    logic       vld;
    squashSrc_t src;
    robIdx_t    rob_idx;
    xlen_t      arch_pc;
    logic       branch_taken;
    foldpc_t    store_foldpc;
    foldpc_t    load_foldpc;
  } pendingSquash_t;

  // Same wrap flag means plain index order. Different flags mean the entry
  // with the larger index was allocated before the wrap, so it is the older one.
  function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
    return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/squash_arbiter_if.sv
// squash_arbiter_if
// Bundles the execute writeback buses, the ROB head status and the squash
// fan-out. The slave modport is the arbiter side. The master modport is the
// execute/ROB side.
interface squash_arbiter_if
  import squash_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int NVIOL = 1
);

  logic    [NCH-1:0]   i_bwb_vld;
  branchwbInfo_t [NCH-1:0] i_bwb_info;
  logic    [NVIOL-1:0] i_viol_vld;
  robIdx_t [NVIOL-1:0] i_viol_rob_idx;
  xlen_t   [NVIOL-1:0] i_viol_pc;
  foldpc_t [NVIOL-1:0] i_viol_store_foldpc;
  foldpc_t [NVIOL-1:0] i_viol_load_foldpc;
  robIdx_t             i_rob_head;
  logic                i_head_commit;

  logic                o_squash_vld;
  squashInfo_t         o_squash_info;
  robIdx_t             o_squash_rob_idx;
  logic                o_pending;

  modport master (
    output i_bwb_vld, i_bwb_info, i_viol_vld, i_viol_rob_idx, i_viol_pc,
           i_viol_store_foldpc, i_viol_load_foldpc, i_rob_head, i_head_commit,
    input  o_squash_vld, o_squash_info, o_squash_rob_idx, o_pending
  );

  modport slave (
    input  i_bwb_vld, i_bwb_info, i_viol_vld, i_viol_rob_idx, i_viol_pc,
           i_viol_store_foldpc, i_viol_load_foldpc, i_rob_head, i_head_commit,
    output o_squash_vld, o_squash_info, o_squash_rob_idx, o_pending
  );

endinterface

// File: rtl/squash_arbiter_rob_oldest_sel.sv
// rob_oldest_sel
// N-way oldest-entry selector over ROB indices. It returns the position of the
// oldest valid entry as a binary index and as a one-hot vector, together with
// that entry's ROB index. An entry replaces the current winner only when it is
// strictly older, so on equal indices the lowest position wins.
module rob_oldest_sel
  import squash_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic    [N-1:0]  i_vld,
  input  robIdx_t [N-1:0]  i_rob_idx,
  output logic             o_vld,
  output logic    [IW-1:0] o_sel,
  output logic    [N-1:0]  o_onehot,
  output robIdx_t          o_rob_idx
);

  // Comparator chain that carries the running oldest entry from position 0 upwards
  always_comb begin
    o_vld     = 1'b0;
    o_sel     = '0;
    o_onehot  = '0;
    o_rob_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vld[i] && (!o_vld || rob_older(i_rob_idx[i], o_rob_idx))) begin
        o_vld     = 1'b1;
        o_sel     = IW'(i);
        o_onehot  = '0;
        o_onehot[i] = 1'b1;
        o_rob_idx = i_rob_idx[i];
      end
    end
  end

endmodule

// File: rtl/squash_arbiter.sv
// squash_arbiter
// Keeps the single oldest pending squash cause, taken from branch mispredicts
// and memory-order violations. It emits one registered squash pulse when that
// cause reaches the ROB head.
// Optional build macro SQUASH_EARLY_REDIRECT_EN adds o_early_vld/o_early_pc.
// These outputs announce each newly captured oldest cause one cycle after capture.
module squash_arbiter
  import squash_arbiter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int NVIOL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  squash_arbiter_if.slave bus
`ifdef SQUASH_EARLY_REDIRECT_EN
  ,
  output logic            o_early_vld,
  output xlen_t           o_early_pc
`endif
);

  localparam int NCAND = NCH + NVIOL;
  localparam int SELW  = (NCAND > 1) ? $clog2(NCAND) : 1;

  logic    [NCAND-1:0] cand_vld;
  robIdx_t [NCAND-1:0] cand_rob_idx;
  logic                sel_vld;
  logic    [SELW-1:0]  sel_idx;
  logic    [NCAND-1:0] sel_onehot;
  robIdx_t             sel_rob_idx;

  pendingSquash_t cand;
  pendingSquash_t pend_d, pend_q;
  logic           fire;
  logic           capture;
  logic           squash_vld_d, squash_vld_q;
  squashInfo_t    squash_info_d, squash_info_q;
  robIdx_t        squash_rob_idx_d, squash_rob_idx_q;

  // Flatten branch mispredicts then violations so branches win index ties
  always_comb begin
    cand_vld     = '0;
    cand_rob_idx = '0;
    for (int c = 0; c < NCH; c++) begin
      cand_vld[c]     = bus.i_bwb_vld[c] && bus.i_bwb_info[c].has_mispred;
      cand_rob_idx[c] = bus.i_bwb_info[c].rob_idx;
    end
    for (int v = 0; v < NVIOL; v++) begin
      cand_vld[NCH+v]     = bus.i_viol_vld[v];
      cand_rob_idx[NCH+v] = bus.i_viol_rob_idx[v];
    end
  end

  rob_oldest_sel #(
    .N (NCAND)
  ) u_oldest_sel (
    .i_vld     (cand_vld),
    .i_rob_idx (cand_rob_idx),
    .o_vld     (sel_vld),
    .o_sel     (sel_idx),
    .o_onehot  (sel_onehot),
    .o_rob_idx (sel_rob_idx)
  );

  // Build the winning candidate's record with the redirect pc already resolved
  always_comb begin
    cand         = '0;
    cand.vld     = sel_vld;
    cand.rob_idx = sel_rob_idx;
    cand.src     = (int'(sel_idx) < NCH) ? srcBranch : srcViolation;
    for (int c = 0; c < NCH; c++) begin
      if (sel_onehot[c]) begin
        cand.branch_taken = bus.i_bwb_info[c].branch_taken;
        cand.arch_pc      = bus.i_bwb_info[c].branch_taken ? bus.i_bwb_info[c].target_pc
                                                           : bus.i_bwb_info[c].branch_npc;
      end
    end
    for (int v = 0; v < NVIOL; v++) begin
      if (sel_onehot[NCH+v]) begin
        cand.arch_pc      = bus.i_viol_pc[v];
        cand.store_foldpc = bus.i_viol_store_foldpc[v];
        cand.load_foldpc  = bus.i_viol_load_foldpc[v];
      end
    end
  end

  // A branch waits for its own retirement. A violating load re-executes, so the head match alone fires it.
  assign fire = pend_q.vld && (pend_q.rob_idx == bus.i_rob_head) &&
                ((pend_q.src == srcViolation) || bus.i_head_commit);

  // Flush, fire and the pulse cycle all make the arriving candidates irrelevant
  assign capture = !i_flush && !fire && !squash_vld_q && cand.vld &&
                   (!pend_q.vld || rob_older(cand.rob_idx, pend_q.rob_idx));

  // Next pending cause and squash pulse, with flush overriding fire
  always_comb begin
    pend_d           = pend_q;
    squash_vld_d     = 1'b0;
    squash_info_d    = squash_info_q;
    squash_rob_idx_d = squash_rob_idx_q;
    if (i_flush) begin
      pend_d = '0;
    end else if (fire) begin
      squash_vld_d                 = 1'b1;
      squash_info_d.dueToBranch    = (pend_q.src == srcBranch);
      squash_info_d.dueToViolation = (pend_q.src == srcViolation);
      squash_info_d.branch_taken   = pend_q.branch_taken;
      squash_info_d.arch_pc        = pend_q.arch_pc;
      squash_info_d.store_foldpc   = pend_q.store_foldpc;
      squash_info_d.load_foldpc    = pend_q.load_foldpc;
      squash_rob_idx_d             = pend_q.rob_idx;
      pend_d                       = '0;
    end else if (capture) begin
      pend_d = cand;
    end
  end

  // State and registered outputs. Reset drops any pending cause silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q           <= '0;
      squash_vld_q     <= 1'b0;
      squash_info_q    <= '0;
      squash_rob_idx_q <= '0;
    end else begin
      pend_q           <= pend_d;
      squash_vld_q     <= squash_vld_d;
      squash_info_q    <= squash_info_d;
      squash_rob_idx_q <= squash_rob_idx_d;
    end
  end

  assign bus.o_squash_vld     = squash_vld_q;
  assign bus.o_squash_info    = squash_info_q;
  assign bus.o_squash_rob_idx = squash_rob_idx_q;
  assign bus.o_pending        = pend_q.vld;

`ifdef SQUASH_EARLY_REDIRECT_EN
  logic  early_vld_d, early_vld_q;
  xlen_t early_pc_d, early_pc_q;

  // Announce each newly captured oldest cause so the frontend can redirect before retire
  always_comb begin
    early_vld_d = capture;
    early_pc_d  = capture ? cand.arch_pc : early_pc_q;
  end

  // Early redirect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early_vld_q <= 1'b0;
      early_pc_q  <= '0;
    end else begin
      early_vld_q <= early_vld_d;
      early_pc_q  <= early_pc_d;
    end
  end

  assign o_early_vld = early_vld_q;
  assign o_early_pc  = early_pc_q;
`endif

endmodule

// File: doc/squash_arbiter.md
Name: squash_arbiter

Overview:
- Collects branch-writeback results from NCH branch units and memory-order violation reports from NVIOL load/store pipes.
- Keeps the single oldest pending squash cause, by ROB age.
- Emits one registered squash pulse when that cause reaches the ROB head.
- Sits between the execute writeback buses and the ROB/FTQ/rename squash fan-out. Replaces per-unit ad-hoc squash generation.

Parameters:
- NCH, 2, number of branch writeback channels (≥1).
- NVIOL, 1, number of violation report channels (≥1).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- i_flush  in  1  external flush (trap/interrupt); kills the pending cause
- i_bwb_vld  in  NCH  branch writeback valid per channel
- i_bwb_info  in  NCH x branchwbInfo_t  branch writeback payload
- i_viol_vld  in  NVIOL  violation valid
- i_viol_rob_idx  in  NVIOL x robIdx_t  violating load's ROB index
- i_viol_pc  in  NVIOL x XLEN  violating load's pc (refetch pc)
- i_viol_store_foldpc  in  NVIOL x MEMDEP_FOLDPC_WIDTH  store folded pc
- i_viol_load_foldpc  in  NVIOL x MEMDEP_FOLDPC_WIDTH  load folded pc
- i_rob_head  in  robIdx_t  current ROB head index
- i_head_commit  in  1  ROB head retires this cycle
- o_squash_vld  out  1  squash pulse
- o_squash_info  out  squashInfo_t  squash payload
- o_squash_rob_idx  out  robIdx_t  ROB index of the squash cause
- o_pending  out  1  a cause is held

Behaviour:
- Age rule: a is older than b iff (a.flag==b.flag) ? a.idx<b.idx : a.idx>b.idx.
- Candidates each cycle: branch channels with vld && has_mispred, plus every valid violation channel.
- Capture: the oldest candidate is compared against the pending register. It replaces the pending register if none is held or it is strictly older; otherwise it is dropped, because it will be squashed anyway. Write happens at the next edge.
- Equal-index candidates cannot occur. If they do, the lowest channel wins and branch channels win over violation channels.
- Fire, using the registered pending value only:
  - Branch cause: pending && rob_idx==i_rob_head && i_head_commit.
  - Violation cause: pending && rob_idx==i_rob_head; commit is not required because the load re-executes.
- On fire, next edge:
  - o_squash_vld=1 for exactly one cycle.
  - Pending is cleared.
  - All candidates arriving in the fire cycle are discarded, since they are younger.
- Payload:
  - Branch: dueToBranch=1, dueToViolation=0, branch_taken from the writeback, arch_pc = branch_taken ? target_pc : branch_npc, foldpcs=0.
  - Violation: dueToViolation=1, dueToBranch=0, branch_taken=0, arch_pc=i_viol_pc, foldpcs passed through.
- Cycle after a pulse: o_squash_vld=0. A new cause can be captured no earlier than one cycle after the pulse. Inputs are ignored during the pulse cycle, because consumers flush the pipes.
- i_flush:
  - Clears pending and suppresses fire in the same cycle.
  - Candidates that arrive the same cycle are discarded.
  - i_flush has priority over fire.
- Latency: capture → earliest pulse is 2 cycles (capture edge, then match cycle, then registered out).
- Reset (async, rst low): o_squash_vld=0, o_pending=0, o_squash_info all fields 0, o_squash_rob_idx=0. Reset mid-pending drops the cause with no pulse.
- Pending register: valid bit, source type (branch/violation), robIdx_t, arch_pc, branch_taken, both foldpcs.

Optional Feature:
- Macro: SQUASH_EARLY_REDIRECT_EN.
- When defined, adds two outputs:
  - o_early_vld (1): pulses the cycle after a capture that changed pending.
  - o_early_pc (XLEN): that cause's arch_pc.
- The frontend redirects speculatively without waiting for retire. The final squash pulse is still produced.
- When undefined, these ports are absent and no early logic is synthesised.

Decomposition:
- Shared package (core package):
  - function rob_older(a,b)
  - typedef squashSrc_t enum {srcBranch, srcViolation}
  - typedef pendingSquash_t struct
- Sub-module rob_oldest_sel: parametrised N-way comparator tree returning the oldest valid index and its one-hot position. Reused by the ROB and the LSQ.

Test Plan:
- Single mispredict, ch0, rob_idx {0,5}, taken, target 0x8000_1000; head reaches {0,5} with commit → o_squash_vld 1 cycle, dueToBranch=1, arch_pc=0x8000_1000, o_pending=0 after.
- Same-cycle ch0 {0,9} and ch1 {0,4} mispredict → pending holds {0,4}; later ch0 {0,2} arrives → replaces it; ch1 {0,7} arrives → dropped.
- Wrap-around: pending {0,30} with ROB size 32, new {1,1} → {1,1} is younger and dropped; new {0,28} → replaces.
- Violation at {0,6}, head {0,6}, i_head_commit=0 → pulse with dueToViolation=1, arch_pc=i_viol_pc, foldpcs equal to inputs.
- Pending branch {0,3}, i_flush together with the fire condition → no pulse, o_pending=0; async rst low mid-pending → all outputs 0 immediately.
- With SQUASH_EARLY_REDIRECT_EN: capture {0,5} → o_early_vld one cycle later, o_early_pc correct; capture of an older cause gives a second early pulse.
